// File: rtl/ifu_pfq.sv
// ifu_pfq -- instruction prefetch queue.
//
// Issues sequential word-aligned fetch requests, collects in-order responses
// into a small FIFO and feeds the IF/ID pipeline register from the FIFO head.
// A flush redirects fetch, empties the FIFO and discards every response still
// in flight for the old fetch stream.
//
// Parameters
//   DEPTH     FIFO entries and limit on outstanding + queued fetches
//             (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  fetch request handshake; req_addr is the address
//   rsp_valid/rsp_data   in-order fetch response, latency >= 1 cycle
//   flush/flush_pc       redirect request and its target
//   id_stall             IF/ID register must hold
//   id_load/id_clr       load / bubble-insert strobes to IF/ID
//   id_pc/id_inst        head entry presented to IF/ID
//
// Optional feature: define IFU_PFQ_BYPASS_EN to forward a response straight
// to IF/ID in its arrival cycle when the FIFO is empty and IF/ID can accept.
module ifu_pfq #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        id_stall,
   output logic        id_load,
   output logic        id_clr,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   cnt_t          wr_ptr, rd_ptr, fifo_count, outstanding, drop_cnt;
   logic [31:0]   rsp_pc;      // address belonging to the next kept response
   logic [AW+1:0] in_use;
   logic          fifo_empty, req_fire, rsp_keep, bypass, push, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);

   // Every slot is either in flight or queued; the sum never exceeds DEPTH,
   // so a response always finds room in the FIFO.
   assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign req_valid = !rst && !flush && (in_use < (AW+2)'(DEPTH));
   assign req_fire  = req_valid && req_ready;

   // Responses while drop_cnt is non-zero belong to the pre-flush stream.
   assign rsp_keep = !rst && rsp_valid && (drop_cnt == '0) && !flush;

`ifdef IFU_PFQ_BYPASS_EN
   assign bypass = rsp_keep && fifo_empty && !id_stall;
`else
   assign bypass = 1'b0;
`endif

   assign push    = rsp_keep && !bypass;
   assign pop     = !rst && !flush && !id_stall && !fifo_empty;
   assign id_load = pop || bypass;
   assign id_clr  = rst || flush || (!id_stall && fifo_empty && !bypass);
   assign id_pc   = bypass ? rsp_pc   : pc_mem[rd_ptr[AW-1:0]];
   assign id_inst = bypass ? rsp_data : inst_mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (flush) begin
            req_addr <= {flush_pc[31:2], 2'b00};
            rsp_pc   <= {flush_pc[31:2], 2'b00};
            rd_ptr   <= wr_ptr;
            // The response arriving in the flush cycle is already discarded.
            drop_cnt <= outstanding - cnt_t'(rsp_valid);
         end else begin
            if (req_fire) req_addr <= req_addr + 32'd4;
            if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
            if (push)     wr_ptr   <= wr_ptr + cnt_t'(1);
            if (pop)      rd_ptr   <= rd_ptr + cnt_t'(1);
            if (rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - cnt_t'(1);
         end
         outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_valid);
      end
   end

   // NOTE: the entry storage has no reset; the pointers alone decide which
   // entries are valid, which lets the array map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr[AW-1:0]]   <= rsp_pc;
         inst_mem[wr_ptr[AW-1:0]] <= rsp_data;
      end
   end

`ifndef SYNTHESIS
   // A response with nothing in flight means the memory broke the protocol.
   rsp_without_request: assert property (
      @(posedge clk) disable iff (rst) rsp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_ifu_pfq.sv
// tb_ifu_pfq -- self-checking bench for ifu_pfq.
// A memory model answers requests in order; a queue-based reference model
// predicts every DUT output per cycle from the fetch-queue rules.
module tb_ifu_pfq;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_PFQ_BYPASS_EN
   localparam int FIRST_LOAD = 1;
`else
   localparam int FIRST_LOAD = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        flush;
   logic [31:0] flush_pc;
   logic        id_stall, id_load, id_clr;
   logic [31:0] id_pc, id_inst;

   always #5 clk = ~clk;

   ifu_pfq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .flush(flush), .flush_pc(flush_pc),
      .id_stall(id_stall), .id_load(id_load), .id_clr(id_clr),
      .id_pc(id_pc), .id_inst(id_inst)
   );

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mem_t;

   req_t        m_req[$];    // model: fetches in flight, stale after a flush
   ent_t        m_fifo[$];   // model: queued instructions
   mem_t        mem_q[$];    // memory: requests awaiting a response
   logic [31:0] m_pc;
   int          cyc;
   bit          mem_hold, lat_rand;
   int          errors, checks;

   logic        obs_req_valid, obs_id_load, obs_id_clr;
   logic [31:0] obs_req_addr, obs_id_pc, obs_id_inst;
   logic        exp_req_valid, exp_id_load, exp_id_clr;
   logic [31:0] exp_req_addr, exp_id_pc, exp_id_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
   endfunction

   task automatic model_reset();
      m_req.delete();
      m_fifo.delete();
      mem_q.delete();
      m_pc = RESET_PC;
   endtask

   // One clock cycle: entered and left at posedge+1 with inputs already set.
   task automatic tick();
      req_t h;
      bit   byp;
      if (!rst && !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc &&
          (!lat_rand || $urandom_range(2, 0) != 0)) begin
         rsp_valid = 1'b1;
         rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
      end
      @(negedge clk);
      obs_req_valid = req_valid;
      obs_req_addr  = req_addr;
      obs_id_load   = id_load;
      obs_id_clr    = id_clr;
      obs_id_pc     = id_pc;
      obs_id_inst   = id_inst;

      byp = 1'b0;
`ifdef IFU_PFQ_BYPASS_EN
      byp = rsp_valid && m_req.size() > 0 && !m_req[0].stale && !flush &&
            !id_stall && m_fifo.size() == 0;
`endif
      exp_req_valid = !flush && (m_req.size() + m_fifo.size() < DEPTH);
      exp_req_addr  = m_pc;
      exp_id_load   = (!flush && !id_stall && m_fifo.size() > 0) || byp;
      exp_id_clr    = flush || (!id_stall && m_fifo.size() == 0 && !byp);
      if (byp) begin
         exp_id_pc   = m_req[0].addr;
         exp_id_inst = mem_word(m_req[0].addr);
      end else if (m_fifo.size() > 0) begin
         exp_id_pc   = m_fifo[0].pc;
         exp_id_inst = m_fifo[0].inst;
      end else begin
         exp_id_pc   = 'x;
         exp_id_inst = 'x;
      end

      if (rsp_valid && m_req.size() > 0) begin
         h = m_req.pop_front();
         if (!h.stale && !flush && !byp) m_fifo.push_back('{pc: h.addr, inst: mem_word(h.addr)});
      end
      if (exp_id_load && !byp) void'(m_fifo.pop_front());
      if (flush) begin
         m_fifo.delete();
         foreach (m_req[i]) m_req[i].stale = 1'b1;
         m_pc = {flush_pc[31:2], 2'b00};
      end else if (exp_req_valid && req_ready) begin
         m_req.push_back('{addr: m_pc, stale: 1'b0});
         m_pc = m_pc + 32'd4;
      end

      if (rsp_valid) void'(mem_q.pop_front());
      if (req_valid && req_ready) mem_q.push_back('{addr: req_addr, due: cyc + 1});
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      id_stall  = 1'b0;
      req_ready = 1'b0;
      flush     = 1'b0;
      mem_hold  = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_ready = 1'b0; flush = 1'b0; flush_pc = '0;
      id_stall = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      mem_hold = 1'b0; lat_rand = 1'b0; cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_valid !== 1'b0 || req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_req: got valid=%b addr=%h, want valid=0 addr=%h", req_valid, req_addr, RESET_PC);
      end
      checks++;
      if (id_load !== 1'b0 || id_clr !== 1'b1) begin
         errors++;
         $display("FAIL reset_id: got load=%b clr=%b, want load=0 clr=1", id_load, id_clr);
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      int first_load = -1;
      req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 4) begin
            checks++;
            if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC + 32'(4 * i)) begin
               errors++;
               $display("FAIL stream_addr[%0d]: got valid=%b addr=%h, want valid=1 addr=%h",
                        i, obs_req_valid, obs_req_addr, RESET_PC + 32'(4 * i));
            end
         end
         if (first_load < 0 && obs_id_load === 1'b1) begin
            first_load = i;
            checks++;
            if (obs_id_pc !== RESET_PC) begin
               errors++;
               $display("FAIL stream_first_pc: got %h, want %h", obs_id_pc, RESET_PC);
            end
         end
      end
      checks++;
      if (first_load != FIRST_LOAD) begin
         errors++;
         $display("FAIL stream_first_load_cycle: got %0d, want %0d", first_load, FIRST_LOAD);
      end
   endtask

   task automatic test_stall_fill();
      id_stall = 1'b1;
      repeat (10) tick();
      checks++;
      if (obs_req_valid !== 1'b0 || obs_id_load !== 1'b0 || obs_id_clr !== 1'b0) begin
         errors++;
         $display("FAIL stall_full: got valid=%b load=%b clr=%b, want 0 0 0",
                  obs_req_valid, obs_id_load, obs_id_clr);
      end
      id_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs_id_load !== 1'b1 || obs_id_pc !== exp_id_pc || obs_id_inst !== exp_id_inst) begin
            errors++;
            $display("FAIL stall_release[%0d]: got load=%b pc=%h inst=%h, want load=1 pc=%h inst=%h",
                     i, obs_id_load, obs_id_pc, obs_id_inst, exp_id_pc, exp_id_inst);
         end
      end
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      drain();
      mem_hold  = 1'b1;
      req_ready = 1'b1;
      repeat (3) tick();
      req_ready = 1'b0;
      flush     = 1'b1;
      flush_pc  = 32'h0000_0103;
      tick();
      checks++;
      if (obs_id_clr !== 1'b1 || obs_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_cycle: got clr=%b valid=%b, want clr=1 valid=0", obs_id_clr, obs_req_valid);
      end
      flush     = 1'b0;
      mem_hold  = 1'b0;
      req_ready = 1'b1;
      tick();
      checks++;
      if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0000_0100) begin
         errors++;
         $display("FAIL flush_next_addr: got valid=%b addr=%h, want valid=1 addr=00000100",
                  obs_req_valid, obs_req_addr);
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (obs_id_load === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (obs_id_pc !== 32'h0000_0100 || obs_id_inst !== mem_word(32'h0000_0100)) begin
               errors++;
               $display("FAIL flush_first_pc: got pc=%h inst=%h, want pc=00000100 inst=%h",
                        obs_id_pc, obs_id_inst, mem_word(32'h0000_0100));
            end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL flush_first_pc: no id_load within 20 cycles, want pc=00000100");
      end
   endtask

   task automatic test_wrap();
      drain();
      flush    = 1'b1;
      flush_pc = 32'hFFFF_FFFE;
      tick();
      flush     = 1'b0;
      req_ready = 1'b1;
      tick();
      checks++;
      if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_top: got valid=%b addr=%h, want valid=1 addr=fffffffc", obs_req_valid, obs_req_addr);
      end
      tick();
      checks++;
      if (obs_req_addr !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_zero: got addr=%h, want 00000000", obs_req_addr);
      end
   endtask

   task automatic test_ready_low();
      drain();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (obs_req_valid !== 1'b1 || obs_req_addr !== exp_req_addr || obs_id_clr !== 1'b1) begin
            errors++;
            $display("FAIL ready_low[%0d]: got valid=%b addr=%h clr=%b, want valid=1 addr=%h clr=1",
                     i, obs_req_valid, obs_req_addr, obs_id_clr, exp_req_addr);
         end
      end
   endtask

   task automatic test_reset_midstream();
      id_stall  = 1'b1;
      req_ready = 1'b1;
      repeat (2) tick();
      req_ready = 1'b0;
      repeat (2) tick();
      // Two entries queued; releasing the stall would load without reset.
      id_stall  = 1'b0;
      rsp_valid = 1'b0;
      rst       = 1'b1;
      #1;
      checks++;
      if (id_load !== 1'b0 || req_valid !== 1'b0 || id_clr !== 1'b1 || req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_mid: got load=%b valid=%b clr=%b addr=%h, want 0 0 1 %h",
                  id_load, req_valid, id_clr, req_addr, RESET_PC);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_ready = 1'b1;
      tick();
      checks++;
      if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_restart: got valid=%b addr=%h, want valid=1 addr=%h", obs_req_valid, obs_req_addr, RESET_PC);
      end
   endtask

   task automatic test_random();
      lat_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         req_ready = ($urandom_range(3, 0) != 0);
         id_stall  = ($urandom_range(3, 0) == 0);
         flush     = ($urandom_range(19, 0) == 0);
         flush_pc  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
         tick();
         checks++;
         if (obs_req_valid !== exp_req_valid) begin
            errors++;
            $display("FAIL rand_req_valid @%0d: got %b, want %b", cyc, obs_req_valid, exp_req_valid);
         end
         if (exp_req_valid) begin
            checks++;
            if (obs_req_addr !== exp_req_addr) begin
               errors++;
               $display("FAIL rand_req_addr @%0d: got %h, want %h", cyc, obs_req_addr, exp_req_addr);
            end
         end
         checks++;
         if (obs_id_load !== exp_id_load || obs_id_clr !== exp_id_clr) begin
            errors++;
            $display("FAIL rand_id_strobes @%0d: got load=%b clr=%b, want load=%b clr=%b",
                     cyc, obs_id_load, obs_id_clr, exp_id_load, exp_id_clr);
         end
         if (exp_id_load) begin
            checks++;
            if (obs_id_pc !== exp_id_pc || obs_id_inst !== exp_id_inst) begin
               errors++;
               $display("FAIL rand_id_data @%0d: got pc=%h inst=%h, want pc=%h inst=%h",
                        cyc, obs_id_pc, obs_id_inst, exp_id_pc, exp_id_inst);
            end
         end
      end
      lat_rand = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_stream();
      test_stall_fill();
      test_flush();
      test_wrap();
      test_ready_low();
      test_reset_midstream();
      test_random();
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
